// File: rtl/ingress_ram_arbiter.sv
// ingress_ram_arbiter: round-robin merge of per-port word streams onto one RAM write port,
// with per-port circular regions, occupancy tracking, atomic frame drop and commit descriptors.
module ingress_ram_arbiter #(
   parameter int NUM_PORTS   = 15,
   parameter int DATA_WIDTH  = 144,
   parameter int PORT_BITS   = 4,
   parameter int REGION_BITS = 14,
   parameter int ADDR_BITS   = 18
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic [NUM_PORTS-1:0]            i_port_valid,
   input  logic [NUM_PORTS-1:0]            i_port_last,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_port_data,
   output logic [NUM_PORTS-1:0]            o_port_ready,
   input  logic [NUM_PORTS-1:0]            i_port_free,
   output logic                            o_ram_wr_en,
   output logic [ADDR_BITS-1:0]            o_ram_wr_addr,
   output logic [DATA_WIDTH-1:0]           o_ram_wr_data,
   output logic                            o_desc_valid,
   output logic [PORT_BITS-1:0]            o_desc_port,
   output logic [ADDR_BITS-1:0]            o_desc_addr,
   output logic [REGION_BITS:0]            o_desc_len,
   output logic [NUM_PORTS-1:0]            o_drop_pulse
);
   localparam logic [PORT_BITS:0] NP = (PORT_BITS+1)'(NUM_PORTS);
   logic [PORT_BITS-1:0]   r_rr;
   logic [REGION_BITS-1:0] r_commit_ptr [NUM_PORTS];
   logic [REGION_BITS-1:0] r_wr_ptr     [NUM_PORTS];
   logic [REGION_BITS:0]   r_used       [NUM_PORTS];
   logic [REGION_BITS:0]   r_frame_len  [NUM_PORTS];
   logic [NUM_PORTS-1:0]   r_dropping;
   logic                   r_wr_en, r_desc_valid;
   logic [ADDR_BITS-1:0]   r_wr_addr, r_desc_addr;
   logic [DATA_WIDTH-1:0]  r_wr_data;
   logic [PORT_BITS-1:0]   r_desc_port;
   logic [REGION_BITS:0]   r_desc_len;
   logic [NUM_PORTS-1:0]   r_drop;
   logic                   w_gnt_vld;
   logic [PORT_BITS-1:0]   w_gnt_idx;
   logic [NUM_PORTS-1:0]   w_acc, w_wr;
   logic [REGION_BITS:0]   w_ueff [NUM_PORTS];
   // Descending search so the port closest to r_rr is the last (winning) assignment.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      for (int j = NUM_PORTS-1; j >= 0; j--) begin
         logic [PORT_BITS:0] s;
         s = {1'b0, r_rr} + (PORT_BITS+1)'(j);
         s = (s >= NP) ? s - NP : s;
         if (i_port_valid[s[PORT_BITS-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = s[PORT_BITS-1:0];
         end
      end
   end
   // A same-cycle free is applied before the fullness check.
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_acc[i]  = w_gnt_vld && (w_gnt_idx == PORT_BITS'(i));
         w_ueff[i] = r_used[i] - (REGION_BITS+1)'(i_port_free[i] && (r_used[i] != '0));
         w_wr[i]   = w_acc[i] && !r_dropping[i] && !w_ueff[i][REGION_BITS];
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr         <= '0;
         r_dropping   <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_desc_valid <= 1'b0;
         r_desc_port  <= '0;
         r_desc_addr  <= '0;
         r_desc_len   <= '0;
         r_drop       <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_commit_ptr[i] <= '0;
            r_wr_ptr[i]     <= '0;
            r_used[i]       <= '0;
            r_frame_len[i]  <= '0;
         end
      end else begin
         r_wr_en      <= |w_wr;
         r_wr_addr    <= ADDR_BITS'({w_gnt_idx, r_wr_ptr[w_gnt_idx]});
         r_wr_data    <= i_port_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
         r_desc_valid <= |(w_wr & i_port_last);
         r_desc_port  <= w_gnt_idx;
         r_desc_addr  <= ADDR_BITS'({w_gnt_idx, r_commit_ptr[w_gnt_idx]});
         r_desc_len   <= r_frame_len[w_gnt_idx] + 1'b1;
         r_drop       <= w_acc & ~w_wr & i_port_last;
         if (w_gnt_vld) r_rr <= (w_gnt_idx == PORT_BITS'(NUM_PORTS-1)) ? '0 : w_gnt_idx + 1'b1;
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_used[i] <= (w_acc[i] && i_port_last[i] && !w_wr[i]) ? w_ueff[i] - r_frame_len[i]
                                                                   : w_ueff[i] + (REGION_BITS+1)'(w_wr[i]);
            if (w_acc[i]) begin
               r_dropping[i]  <= !w_wr[i] && !i_port_last[i];
               r_frame_len[i] <= i_port_last[i] ? '0 : r_frame_len[i] + (REGION_BITS+1)'(w_wr[i]);
               r_wr_ptr[i]    <= (i_port_last[i] && !w_wr[i]) ? r_commit_ptr[i]
                                                               : r_wr_ptr[i] + REGION_BITS'(w_wr[i]);
               if (i_port_last[i] && w_wr[i]) r_commit_ptr[i] <= r_wr_ptr[i] + 1'b1;
            end
         end
      end
   end
   assign o_port_ready  = w_acc & {NUM_PORTS{i_rst_n}};
   assign o_ram_wr_en   = r_wr_en;
   assign o_ram_wr_addr = r_wr_addr;
   assign o_ram_wr_data = r_wr_data;
   assign o_desc_valid  = r_desc_valid;
   assign o_desc_port   = r_desc_port;
   assign o_desc_addr   = r_desc_addr;
   assign o_desc_len    = r_desc_len;
   assign o_drop_pulse  = r_drop;
endmodule

// File: tb/tb_ingress_ram_arbiter.sv
// tb_ingress_ram_arbiter: directed vectors with hand-computed expectations,
// run with REGION_BITS=4 so that overflow and wrap are reachable quickly.
module tb_ingress_ram_arbiter;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [14:0] port_valid = '0, port_last = '0, port_free = '0, port_ready, drop_pulse;
   logic [239:0] port_data = '0;
   logic        ram_wr_en, desc_valid;
   logic [7:0]  ram_wr_addr, desc_addr;
   logic [15:0] ram_wr_data;
   logic [3:0]  desc_port;
   logic [4:0]  desc_len;
   logic [14:0] rdy_s;
   int          n_chk = 0, n_err = 0, wc = 0;

   ingress_ram_arbiter #(.NUM_PORTS(15), .DATA_WIDTH(16), .PORT_BITS(4), .REGION_BITS(4), .ADDR_BITS(8)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_port_valid(port_valid), .i_port_last(port_last),
      .i_port_data(port_data), .o_port_ready(port_ready), .i_port_free(port_free),
      .o_ram_wr_en(ram_wr_en), .o_ram_wr_addr(ram_wr_addr), .o_ram_wr_data(ram_wr_data),
      .o_desc_valid(desc_valid), .o_desc_port(desc_port), .o_desc_addr(desc_addr),
      .o_desc_len(desc_len), .o_drop_pulse(drop_pulse));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts just after a rising edge; ready is sampled mid-cycle, registered outputs 1 after the next edge.
   task automatic cyc(input logic [14:0] v, input logic [14:0] l, input logic [14:0] f);
      for (int i = 0; i < 15; i++) port_data[i*16 +: 16] = {i[3:0], wc[11:0]};
      wc++;
      port_valid = v; port_last = l; port_free = f;
      @(negedge clk);
      rdy_s = port_ready;
      @(posedge clk);
      #1;
      port_valid = '0; port_last = '0; port_free = '0;
   endtask

   task automatic frame(input int p, input int n, input int off0);
      for (int i = 0; i < n; i++) begin
         logic [15:0] ed;
         logic [3:0]  off;
         ed  = {p[3:0], wc[11:0]};
         off = 4'((off0 + i) % 16);
         cyc(15'(1 << p), (i == n-1) ? 15'(1 << p) : 15'd0, '0);
         check("frm_rdy", rdy_s, 15'(1 << p));
         check("frm_wr_en", ram_wr_en, 1);
         check("frm_addr", ram_wr_addr, {p[3:0], off});
         check("frm_data", ram_wr_data, ed);
         check("frm_desc_v", desc_valid, 64'(i == n-1));
         check("frm_drop", drop_pulse, 0);
         if (i == n-1) begin
            check("frm_desc_port", desc_port, p[3:0]);
            check("frm_desc_addr", desc_addr, {p[3:0], 4'(off0)});
            check("frm_desc_len", desc_len, n[4:0]);
         end
      end
   endtask

   initial begin
      logic [14:0] rr_seq [6];
      rr_seq = '{15'h0020, 15'h4000, 15'h0001, 15'h0020, 15'h4000, 15'h0001};
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", ram_wr_en, 0);
      check("rst_desc_v", desc_valid, 0);
      check("rst_drop", drop_pulse, 0);
      check("rst_ready", port_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      // 4-word frame on port 3; leaves rr at 4
      frame(3, 4, 0);
      // ports 0,5,14 held valid with single-word frames, rr starts at 4
      for (int k = 0; k < 6; k++) begin
         cyc(15'h4021, 15'h4021, '0);
         check("rr_grant", rdy_s, rr_seq[k]);
         check("rr_wr_en", ram_wr_en, 1);
         check("rr_addr", ram_wr_addr[3:0], 4'(k / 3));
      end
      // overflow on port 1: 12 committed, 6-word frame drops after 4 writes
      frame(1, 12, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(15'h0002, (i == 5) ? 15'h0002 : 15'h0000, '0);
         check("ovf_rdy", rdy_s, 15'h0002);
         check("ovf_wr_en", ram_wr_en, 64'(i < 4));
         if (i < 4) check("ovf_addr", ram_wr_addr, 8'h1C + 8'(i));
         check("ovf_drop", drop_pulse, (i == 5) ? 15'h0002 : 15'h0000);
         check("ovf_desc_v", desc_valid, 0);
      end
      frame(1, 4, 12);
      cyc(15'h0002, 15'h0002, '0);
      check("full_wr_en", ram_wr_en, 0);
      check("full_drop", drop_pulse, 15'h0002);
      check("full_desc_v", desc_valid, 0);
      // port 2 full, then a write with a same-cycle free
      frame(2, 16, 0);
      cyc(15'h0004, 15'h0004, 15'h0004);
      check("fw_wr_en", ram_wr_en, 1);
      check("fw_addr", ram_wr_addr, 8'h20);
      check("fw_desc_v", desc_valid, 1);
      check("fw_desc_addr", desc_addr, 8'h20);
      check("fw_desc_len", desc_len, 5'd1);
      cyc(15'h0004, 15'h0004, '0);
      check("fw_full_wr_en", ram_wr_en, 0);
      check("fw_full_drop", drop_pulse, 15'h0004);
      // wrap on port 4; port 1 freed concurrently
      frame(4, 14, 0);
      for (int i = 0; i < 14; i++) cyc('0, '0, (i < 4) ? 15'h0012 : 15'h0010);
      frame(4, 5, 14);
      frame(1, 4, 0);
      // reset mid-frame on port 6
      cyc(15'h0040, '0, '0);
      cyc(15'h0040, '0, '0);
      check("mid_wr_en", ram_wr_en, 1);
      port_valid = 15'h0040;
      #2 rst_n = 1'b0;
      #1;
      check("mrst_ready", port_ready, 0);
      check("mrst_wr_en", ram_wr_en, 0);
      check("mrst_addr", ram_wr_addr, 0);
      check("mrst_desc_v", desc_valid, 0);
      check("mrst_drop", drop_pulse, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      port_valid = '0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_desc_v", desc_valid, 0);
      check("post_drop", drop_pulse, 0);
      cyc(15'h0120, 15'h0120, '0);
      check("post_rr", rdy_s, 15'h0020);
      check("post_addr", ram_wr_addr, 8'h50);
      frame(6, 2, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
